// File: rtl/vga_pixel_out.sv
// ---------------------------------------------------------------------------
// vga_pixel_out
// VGA raster engine. Generates the scan coordinates fed to the drawers and the
// object mux, captures the RGB levels the mux returns PIPE_LAT clocks later,
// and drives registered VGA pins with HS/VS/blank delayed by the same amount
// so that every pin refers to the same pixel.
//
// Ports
//   clk            pixel clock, rising edge
//   reset          asynchronous, active-high
//   Red_level      mux red   for the coordinate issued PIPE_LAT clocks earlier
//   Green_level    mux green (same alignment)
//   Blue_level     mux blue  (same alignment)
//   pixelX         horizontal count, 0..H_TOTAL-1 (registered)
//   pixelY         vertical count,   0..V_TOTAL-1 (registered)
//   startOfFrame   high for the single clock in which (pixelX,pixelY)==(0,0)
//   vga_r/g/b      RGB pins, forced to 0 outside the visible area
//   vga_hs/vga_vs  sync pins, active level SYNC_POL
//   vga_blank_n    1 while a visible pixel is on the pins
// ---------------------------------------------------------------------------
module vga_pixel_out #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   PIPE_LAT = 1,     // mux latency in clocks, 1..4
    parameter logic SYNC_POL = 1'b0   // active level of HS/VS (0 = active-low)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Red_level,
    input  logic [3:0]  Green_level,
    input  logic [3:0]  Blue_level,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS_END  = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    // ------------------------------------------------------------------
    // Scan counters. run_q stays low until the first edge after reset so
    // that edge presents (0,0) with startOfFrame rather than skipping it.
    // ------------------------------------------------------------------
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        run_q;
    logic        sof_q, sof_d;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can leave one unassigned and infer a latch.
        x_d = x_q;
        y_d = y_q;
        if (run_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? 11'd0 : y_q + 11'd1;
            end else begin
                x_d = x_q + 11'd1;
            end
        end
        // Registered so the pulse lines up with the counts it describes.
        sof_d = (x_d == 11'd0) && (y_d == 11'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            run_q <= 1'b0;
            sof_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
            x_q   <= x_d;
            y_q   <= y_d;
            run_q <= 1'b1;
            sof_q <= sof_d;
        end
    end

    // ------------------------------------------------------------------
    // Timing decode from the current counts. The idle (pre-run) clock is
    // treated as blank so the pins stay dark until (0,0) is really issued.
    // ------------------------------------------------------------------
    logic vis, hs_act, vs_act;

    always_comb begin
        vis    = run_q && (x_q < H_VIS_END) && (y_q < V_VIS_END);
        hs_act = run_q && (x_q >= H_SYNC_BEG) && (x_q < H_SYNC_END);
        vs_act = run_q && (y_q >= V_SYNC_BEG) && (y_q < V_SYNC_END);
    end

    // ------------------------------------------------------------------
    // Delay lines matching the mux latency; bit PIPE_LAT-1 carries the
    // timing of the coordinate whose RGB is arriving this clock.
    // ------------------------------------------------------------------
    logic [PIPE_LAT-1:0] vis_sr_q, hs_sr_q, vs_sr_q;
    logic                d_vis, d_hs, d_vs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: these shift registers are cleared on reset (unlike a RAM) so no stale visible/sync flag reaches the pins afterwards.
            vis_sr_q <= '0;
            hs_sr_q  <= '0;
            vs_sr_q  <= '0;
        end else begin
            vis_sr_q[0] <= vis;
            hs_sr_q[0]  <= hs_act;
            vs_sr_q[0]  <= vs_act;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vis_sr_q[i] <= vis_sr_q[i-1];
                hs_sr_q[i]  <= hs_sr_q[i-1];
                vs_sr_q[i]  <= vs_sr_q[i-1];
            end
        end
    end

    assign d_vis = vis_sr_q[PIPE_LAT-1];
    assign d_hs  = hs_sr_q[PIPE_LAT-1];
    assign d_vs  = vs_sr_q[PIPE_LAT-1];

    // ------------------------------------------------------------------
    // Pin register: RGB is forced to black whenever the delayed flag says
    // the pixel is outside the visible area, regardless of the mux.
    // ------------------------------------------------------------------
    logic [3:0] r_q, g_q, b_q;
    logic       hs_q, vs_q, blank_n_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            blank_n_q <= 1'b0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
        end else begin
            r_q       <= d_vis ? Red_level   : 4'h0;
            g_q       <= d_vis ? Green_level : 4'h0;
            b_q       <= d_vis ? Blue_level  : 4'h0;
            blank_n_q <= d_vis;
            hs_q      <= d_hs ? SYNC_POL : ~SYNC_POL;
            vs_q      <= d_vs ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign pixelX       = x_q;
    assign pixelY       = y_q;
    assign startOfFrame = sof_q;
    assign vga_r        = r_q;
    assign vga_g        = g_q;
    assign vga_b        = b_q;
    assign vga_hs       = hs_q;
    assign vga_vs       = vs_q;
    assign vga_blank_n  = blank_n_q;

endmodule

// File: tb/tb_vga_pixel_out.sv
// ---------------------------------------------------------------------------
// tb_vga_pixel_out
// Directed bench for vga_pixel_out. u_a uses the default 640x480 geometry
// with PIPE_LAT=1. u_b (PIPE_LAT=2) and u_c (PIPE_LAT=4) keep the default
// vertical timing but use a 16-clock line so a whole 525-line frame fits in
// a short run. Expected values come from a small cycle-indexed model: cycle
// n counts clocks since the first (0,0) after reset release.
// ---------------------------------------------------------------------------
module tb_vga_pixel_out;

    typedef struct packed {
        logic        blank_n;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } pins_t;

    localparam int SMALL_HT = 16;            // 8 + 2 + 3 + 3
    localparam int FULL_HT  = 800;
    localparam int VT       = 525;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, reset_b, reset_c;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic [10:0] px_a, py_a, px_b, py_b, px_c, py_c;
    logic        sof_a, sof_b, sof_c;
    logic [3:0]  vr_a, vg_a, vb_a, vr_b, vg_b, vb_b, vr_c, vg_c, vb_c;
    logic        hs_a, vs_a, bl_a, hs_b, vs_b, bl_b, hs_c, vs_c, bl_c;

    int compared   = 0;
    int mismatched = 0;
    int n_a  = -1;
    int n_s  = -1;
    int mode_a  = 1;   // 1: constant FFF, 2: coordinate pattern
    int mode_bc = 2;

    vga_pixel_out u_a (
        .clk(clk), .reset(reset_a),
        .Red_level(r_a), .Green_level(g_a), .Blue_level(b_a),
        .pixelX(px_a), .pixelY(py_a), .startOfFrame(sof_a),
        .vga_r(vr_a), .vga_g(vg_a), .vga_b(vb_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_blank_n(bl_a)
    );

    vga_pixel_out #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .PIPE_LAT(2)) u_b (
        .clk(clk), .reset(reset_b),
        .Red_level(r_b), .Green_level(g_b), .Blue_level(b_b),
        .pixelX(px_b), .pixelY(py_b), .startOfFrame(sof_b),
        .vga_r(vr_b), .vga_g(vg_b), .vga_b(vb_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_blank_n(bl_b)
    );

    vga_pixel_out #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .PIPE_LAT(4)) u_c (
        .clk(clk), .reset(reset_c),
        .Red_level(r_c), .Green_level(g_c), .Blue_level(b_c),
        .pixelX(px_c), .pixelY(py_c), .startOfFrame(sof_c),
        .vga_r(vr_c), .vga_g(vg_c), .vga_b(vb_c),
        .vga_hs(hs_c), .vga_vs(vs_c), .vga_blank_n(bl_c)
    );

    // ------------------------------------------------------------------
    // Model
    // ------------------------------------------------------------------
    function automatic logic [11:0] pat(input int x, input int y);
        logic [3:0] xl, yl;
        xl = 4'(x);
        yl = 4'(y);
        return {xl, yl, 4'hA};
    endfunction

    // Mux output during cycle n: the level for the coordinate issued lat clocks earlier.
    function automatic logic [11:0] stim(input int n, input int lat, input int ht, input int mode);
        int m;
        if (mode == 1 || n < lat) return 12'hFFF;
        m = n - lat;
        return pat(m % ht, (m / ht) % VT);
    endfunction

    // Pins during cycle n reflect the coordinate issued at n-lat-1.
    function automatic pins_t exp_pins(input int n, input int lat, input int ha, input int hfp,
                                       input int hsw, input int hbp, input int mode);
        pins_t p;
        int    m, x, y, ht;
        logic  vis;
        p  = '{blank_n: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 12'h000};
        ht = ha + hfp + hsw + hbp;
        if (n < lat + 1) return p;
        m   = n - lat - 1;
        x   = m % ht;
        y   = (m / ht) % VT;
        vis = (x < ha) && (y < 480);
        p.blank_n = vis;
        p.hs = !((x >= ha + hfp) && (x < ha + hfp + hsw));
        p.vs = !((y >= 490) && (y < 492));
        if (vis) p.rgb = (mode == 1) ? 12'hFFF : pat(x, y);
        return p;
    endfunction

    function automatic pins_t exp_a(input int n);
        return exp_pins(n, 1, 640, 16, 96, 48, mode_a);
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive_a();
        logic [11:0] v;
        v = stim(n_a, 1, FULL_HT, mode_a);
        r_a = v[11:8]; g_a = v[7:4]; b_a = v[3:0];
    endtask

    task automatic drive_bc();
        logic [11:0] v;
        v = stim(n_s, 2, SMALL_HT, mode_bc);
        r_b = v[11:8]; g_b = v[7:4]; b_b = v[3:0];
        v = stim(n_s, 4, SMALL_HT, mode_bc);
        r_c = v[11:8]; g_c = v[7:4]; b_c = v[3:0];
    endtask

    task automatic release_a();
        @(negedge clk);
        reset_a = 1'b0;
        @(posedge clk);
        #1;
        n_a = 0;
        drive_a();
    endtask

    task automatic step_a();
        @(posedge clk);
        #1;
        n_a++;
        drive_a();
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
        mode_a = 1; n_a = -1; n_s = -1;
        drive_a(); drive_bc();
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++; if (px_a !== 11'd0) begin mismatched++; $display("FAIL reset_pixelX: got %0d expected 0", px_a); end
        compared++; if (py_a !== 11'd0) begin mismatched++; $display("FAIL reset_pixelY: got %0d expected 0", py_a); end
        compared++; if (sof_a !== 1'b0) begin mismatched++; $display("FAIL reset_sof: got %b expected 0", sof_a); end
        compared++; if (bl_a !== 1'b0) begin mismatched++; $display("FAIL reset_blank_n: got %b expected 0", bl_a); end
        compared++; if ({vr_a, vg_a, vb_a} !== 12'h000) begin mismatched++; $display("FAIL reset_rgb: got %h expected 000", {vr_a, vg_a, vb_a}); end
        compared++; if ({hs_a, vs_a} !== 2'b11) begin mismatched++; $display("FAIL reset_sync: got %b expected 11", {hs_a, vs_a}); end
    endtask

    task automatic test_first_pixel();
        release_a();
        @(negedge clk);
        compared++; if ({px_a, py_a} !== 22'd0) begin mismatched++; $display("FAIL first_xy: got (%0d,%0d) expected (0,0)", px_a, py_a); end
        compared++; if (sof_a !== 1'b1) begin mismatched++; $display("FAIL first_sof: got %b expected 1", sof_a); end
        compared++; if (bl_a !== 1'b0) begin mismatched++; $display("FAIL first_blank_n: got %b expected 0", bl_a); end
        compared++; if ({vr_a, vg_a, vb_a} !== 12'h000) begin mismatched++; $display("FAIL first_rgb: got %h expected 000", {vr_a, vg_a, vb_a}); end
        step_a();
        @(negedge clk);
        compared++; if (px_a !== 11'd1) begin mismatched++; $display("FAIL second_pixelX: got %0d expected 1", px_a); end
        compared++; if (sof_a !== 1'b0) begin mismatched++; $display("FAIL second_sof: got %b expected 0", sof_a); end
        compared++; if (bl_a !== 1'b0) begin mismatched++; $display("FAIL second_blank_n: got %b expected 0", bl_a); end
        step_a();
        @(negedge clk);
        compared++; if (bl_a !== 1'b1) begin mismatched++; $display("FAIL third_blank_n: got %b expected 1", bl_a); end
        compared++; if ({vr_a, vg_a, vb_a} !== 12'hFFF) begin mismatched++; $display("FAIL third_rgb: got %h expected FFF", {vr_a, vg_a, vb_a}); end
    endtask

    task automatic test_line_timing();
        int hs_low = 0;
        int hs_first = -1;
        while (n_a < 802) begin
            step_a();
            @(negedge clk);
            compared++;
            if (px_a !== 11'(n_a % FULL_HT) || py_a !== 11'(n_a / FULL_HT)) begin
                mismatched++;
                $display("FAIL line_xy n=%0d: got (%0d,%0d) expected (%0d,%0d)", n_a, px_a, py_a, n_a % FULL_HT, n_a / FULL_HT);
            end
            if (hs_a === 1'b0) begin
                if (hs_first < 0) hs_first = n_a;
                hs_low++;
            end
        end
        compared++; if (hs_low != 96) begin mismatched++; $display("FAIL hs_width: got %0d expected 96", hs_low); end
        compared++; if (hs_first != 658) begin mismatched++; $display("FAIL hs_start: got %0d expected 658", hs_first); end
    endtask

    task automatic test_blanking();
        pins_t e;
        while (n_a < 1700) begin
            step_a();
            @(negedge clk);
            e = exp_a(n_a);
            compared++;
            if ({vr_a, vg_a, vb_a} !== e.rgb || bl_a !== e.blank_n) begin
                mismatched++;
                $display("FAIL blank_pins n=%0d: got rgb=%h blank_n=%b expected rgb=%h blank_n=%b", n_a, {vr_a, vg_a, vb_a}, bl_a, e.rgb, e.blank_n);
            end
            // (639,1) on the pins, then (640,1) which must be black.
            if (n_a == 1441) begin
                compared++; if ({vr_a, vg_a, vb_a} !== 12'hFFF) begin mismatched++; $display("FAIL last_visible_px: got %h expected FFF", {vr_a, vg_a, vb_a}); end
            end
            if (n_a == 1442) begin
                compared++; if ({vr_a, vg_a, vb_a, bl_a} !== 13'h0) begin mismatched++; $display("FAIL px640_black: got rgb=%h blank_n=%b expected 000/0", {vr_a, vg_a, vb_a}, bl_a); end
            end
        end
    endtask

    task automatic test_alignment_lat1();
        pins_t e;
        reset_a = 1'b1;
        mode_a = 2;
        n_a = -1;
        drive_a();
        repeat (2) @(posedge clk);
        release_a();
        while (n_a < 1700) begin
            @(negedge clk);
            e = exp_a(n_a);
            compared++;
            if ({vr_a, vg_a, vb_a} !== e.rgb || bl_a !== e.blank_n || hs_a !== e.hs || vs_a !== e.vs) begin
                mismatched++;
                $display("FAIL align_a n=%0d: got rgb=%h bl=%b hs=%b vs=%b expected rgb=%h bl=%b hs=%b vs=%b",
                         n_a, {vr_a, vg_a, vb_a}, bl_a, hs_a, vs_a, e.rgb, e.blank_n, e.hs, e.vs);
            end
            step_a();
        end
    endtask

    task automatic test_mid_frame_reset();
        int  hs_n = -1;
        // Line 20 keeps the run short; any interior point of the frame exercises the same path.
        while (n_a < 20 * FULL_HT + 300) step_a();
        @(negedge clk);
        compared++; if (px_a !== 11'd300 || py_a !== 11'd20) begin mismatched++; $display("FAIL pre_reset_xy: got (%0d,%0d) expected (300,20)", px_a, py_a); end
        compared++; if ({vr_a, vg_a, vb_a} !== pat(298, 20)) begin mismatched++; $display("FAIL pre_reset_rgb: got %h expected %h", {vr_a, vg_a, vb_a}, pat(298, 20)); end
        #1 reset_a = 1'b1;
        #1;
        compared++; if (px_a !== 11'd0 || py_a !== 11'd0) begin mismatched++; $display("FAIL async_xy: got (%0d,%0d) expected (0,0)", px_a, py_a); end
        compared++; if (bl_a !== 1'b0 || {vr_a, vg_a, vb_a} !== 12'h000) begin mismatched++; $display("FAIL async_pins: got rgb=%h blank_n=%b expected 000/0", {vr_a, vg_a, vb_a}, bl_a); end
        compared++; if (sof_a !== 1'b0 || hs_a !== 1'b1) begin mismatched++; $display("FAIL async_ctrl: got sof=%b hs=%b expected 0/1", sof_a, hs_a); end
        repeat (3) @(posedge clk);
        release_a();
        @(negedge clk);
        compared++; if (sof_a !== 1'b1 || px_a !== 11'd0 || py_a !== 11'd0) begin mismatched++; $display("FAIL resume_sof: got sof=%b (%0d,%0d) expected 1 (0,0)", sof_a, px_a, py_a); end
        for (int k = 0; k < 2000 && hs_n < 0; k++) begin
            if (hs_a === 1'b0) hs_n = n_a;
            else begin
                step_a();
                @(negedge clk);
            end
        end
        compared++;
        if (hs_n < 0) begin mismatched++; $display("FAIL resume_hs: timeout expected low at 658"); end
        else if (hs_n != 658) begin mismatched++; $display("FAIL resume_hs: got %0d expected 658", hs_n); end
    endtask

    task automatic test_frame_lat2_lat4();
        pins_t eb, ec;
        int vs_low_b = 0, vs_low_c = 0, vs_first_b = -1, vs_first_c = -1;
        int sof_cnt_b = 0, sof_cnt_c = 0;
        mode_bc = 2;
        @(negedge clk);
        reset_b = 1'b0;
        reset_c = 1'b0;
        @(posedge clk);
        #1;
        n_s = 0;
        drive_bc();
        while (n_s <= VT * SMALL_HT + 20) begin
            @(negedge clk);
            eb = exp_pins(n_s, 2, 8, 2, 3, 3, 2);
            ec = exp_pins(n_s, 4, 8, 2, 3, 3, 2);
            compared++;
            if (px_b !== 11'(n_s % SMALL_HT) || py_b !== 11'((n_s / SMALL_HT) % VT) || px_c !== px_b || py_c !== py_b) begin
                mismatched++;
                $display("FAIL small_xy n=%0d: got b(%0d,%0d) c(%0d,%0d) expected (%0d,%0d)", n_s, px_b, py_b, px_c, py_c, n_s % SMALL_HT, (n_s / SMALL_HT) % VT);
            end
            compared++;
            if ({vr_b, vg_b, vb_b} !== eb.rgb || bl_b !== eb.blank_n || hs_b !== eb.hs || vs_b !== eb.vs) begin
                mismatched++;
                $display("FAIL align_lat2 n=%0d: got rgb=%h bl=%b hs=%b vs=%b expected rgb=%h bl=%b hs=%b vs=%b",
                         n_s, {vr_b, vg_b, vb_b}, bl_b, hs_b, vs_b, eb.rgb, eb.blank_n, eb.hs, eb.vs);
            end
            compared++;
            if ({vr_c, vg_c, vb_c} !== ec.rgb || bl_c !== ec.blank_n || hs_c !== ec.hs || vs_c !== ec.vs) begin
                mismatched++;
                $display("FAIL align_lat4 n=%0d: got rgb=%h bl=%b hs=%b vs=%b expected rgb=%h bl=%b hs=%b vs=%b",
                         n_s, {vr_c, vg_c, vb_c}, bl_c, hs_c, vs_c, ec.rgb, ec.blank_n, ec.hs, ec.vs);
            end
            if (vs_b === 1'b0) begin if (vs_first_b < 0) vs_first_b = n_s; vs_low_b++; end
            if (vs_c === 1'b0) begin if (vs_first_c < 0) vs_first_c = n_s; vs_low_c++; end
            if (sof_b === 1'b1) sof_cnt_b++;
            if (sof_c === 1'b1) sof_cnt_c++;
            @(posedge clk);
            #1;
            n_s++;
            drive_bc();
        end
        // Lines 490..491 are 2 x 16 clocks; line 490 starts at n=7840.
        compared++; if (vs_low_b != 32) begin mismatched++; $display("FAIL vs_width_lat2: got %0d expected 32", vs_low_b); end
        compared++; if (vs_first_b != 7843) begin mismatched++; $display("FAIL vs_start_lat2: got %0d expected 7843", vs_first_b); end
        compared++; if (vs_low_c != 32) begin mismatched++; $display("FAIL vs_width_lat4: got %0d expected 32", vs_low_c); end
        compared++; if (vs_first_c != 7845) begin mismatched++; $display("FAIL vs_start_lat4: got %0d expected 7845", vs_first_c); end
        compared++; if (sof_cnt_b != 2) begin mismatched++; $display("FAIL sof_count_lat2: got %0d expected 2", sof_cnt_b); end
        compared++; if (sof_cnt_c != 2) begin mismatched++; $display("FAIL sof_count_lat4: got %0d expected 2", sof_cnt_c); end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_line_timing();
        test_blanking();
        test_alignment_lat1();
        test_mid_frame_reset();
        test_frame_lat2_lat4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
